// File: rtl/cpu_fwd_hazard.sv
// Operand forwarding and load-use hazard unit between decode and execute.
// Picks the youngest in-flight result per source, stalls when it is not yet produced.
module cpu_fwd_hazard #(
   parameter int DW        = 8,
   parameter int AW        = 3,
   parameter int NSRC      = 2,
   parameter int CW        = 16,
   parameter int MAX_STALL = 3
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   input  logic               D_VALID_I,
   input  logic               FLUSH_I,
   input  logic [NSRC*AW-1:0] REG_SRC_I,
   input  logic [NSRC-1:0]    REG_SRC_CS_I,
   input  logic [NSRC*DW-1:0] REG_BANK_I,
   input  logic [AW-1:0]      E_DSTR_I,
   input  logic [AW-1:0]      M_DSTR_I,
   input  logic [AW-1:0]      W_DSTR_I,
   input  logic               E_VALID_I,
   input  logic               M_VALID_I,
   input  logic               W_VALID_I,
   input  logic               E_DSTR_CS_I,
   input  logic               M_DSTR_CS_I,
   input  logic               W_DSTR_CS_I,
   input  logic [1:0]         E_DSTR_SEL_I,
   input  logic [1:0]         M_DSTR_SEL_I,
   input  logic [1:0]         W_DSTR_SEL_I,
   input  logic [DW-1:0]      E_VAL_C_I,
   input  logic [DW-1:0]      E_VAL_S_I,
   input  logic [DW-1:0]      M_VAL_C_I,
   input  logic [DW-1:0]      M_VAL_S_I,
   input  logic [DW-1:0]      M_VAL_E_I,
   input  logic [DW-1:0]      W_VAL_C_I,
   input  logic [DW-1:0]      W_VAL_S_I,
   input  logic [DW-1:0]      W_VAL_E_I,
   input  logic [DW-1:0]      W_VAL_M_I,
   output logic               STALL_O,
   output logic [NSRC*DW-1:0] OPR_O,
   output logic               OPR_VALID_O,
   output logic [CW-1:0]      STALL_CNT_O,
   output logic               ERR_O
);

   localparam int RW = $clog2(MAX_STALL + 1);

   logic [NSRC-1:0]    hit_e, hit_m, hit_w, unready;
   logic [NSRC*DW-1:0] fwd_opr;
   logic               hazard;

   logic [NSRC*DW-1:0] opr_q, opr_d;
   logic               opr_valid_q, opr_valid_d;
   logic [CW-1:0]      stall_cnt_q, stall_cnt_d;
   logic               err_q, err_d;
   logic [RW-1:0]      run_q, run_d;

   // The first matching stage owns the source even if it cannot supply the value yet.
   always_comb begin
      hit_e   = '0;
      hit_m   = '0;
      hit_w   = '0;
      unready = '0;
      fwd_opr = REG_BANK_I;
      for (int k = 0; k < NSRC; k++) begin
         hit_e[k] = REG_SRC_CS_I[k] & E_VALID_I & E_DSTR_CS_I & (E_DSTR_I == REG_SRC_I[k*AW +: AW]);
         hit_m[k] = REG_SRC_CS_I[k] & M_VALID_I & M_DSTR_CS_I & (M_DSTR_I == REG_SRC_I[k*AW +: AW]);
         hit_w[k] = REG_SRC_CS_I[k] & W_VALID_I & W_DSTR_CS_I & (W_DSTR_I == REG_SRC_I[k*AW +: AW]);
         if (hit_e[k]) begin
            case (E_DSTR_SEL_I)
               2'd0:    fwd_opr[k*DW +: DW] = E_VAL_C_I;
               2'd1:    fwd_opr[k*DW +: DW] = E_VAL_S_I;
               default: unready[k] = 1'b1;
            endcase
         end else if (hit_m[k]) begin
            case (M_DSTR_SEL_I)
               2'd0:    fwd_opr[k*DW +: DW] = M_VAL_C_I;
               2'd1:    fwd_opr[k*DW +: DW] = M_VAL_S_I;
               2'd2:    fwd_opr[k*DW +: DW] = M_VAL_E_I;
               default: unready[k] = 1'b1;
            endcase
         end else if (hit_w[k]) begin
            case (W_DSTR_SEL_I)
               2'd0:    fwd_opr[k*DW +: DW] = W_VAL_C_I;
               2'd1:    fwd_opr[k*DW +: DW] = W_VAL_S_I;
               2'd2:    fwd_opr[k*DW +: DW] = W_VAL_E_I;
               default: fwd_opr[k*DW +: DW] = W_VAL_M_I;
            endcase
         end
      end
   end

   assign hazard  = D_VALID_I & (|unready);
   assign STALL_O = hazard & ~FLUSH_I;

   always_comb begin
      opr_d       = opr_q;
      opr_valid_d = opr_valid_q;
      stall_cnt_d = stall_cnt_q;
      err_d       = err_q;
      run_d       = run_q;
      if (FLUSH_I) begin
         opr_valid_d = 1'b0;
         run_d       = '0;
      end else if (hazard) begin
         opr_valid_d = 1'b0;
         if (stall_cnt_q != {CW{1'b1}})
            stall_cnt_d = stall_cnt_q + CW'(1);
         // Run counter parks at its limit so a long stall cannot wrap past the watchdog.
         if (run_q == RW'(MAX_STALL))
            err_d = 1'b1;
         else
            run_d = run_q + RW'(1);
      end else begin
         opr_d       = fwd_opr;
         opr_valid_d = D_VALID_I;
         run_d       = '0;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         opr_q       <= '0;
         opr_valid_q <= 1'b0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
         run_q       <= '0;
      end else begin
         opr_q       <= opr_d;
         opr_valid_q <= opr_valid_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
         run_q       <= run_d;
      end
   end

   assign OPR_O       = opr_q;
   assign OPR_VALID_O = opr_valid_q;
   assign STALL_CNT_O = stall_cnt_q;
   assign ERR_O       = err_q;

endmodule
